wb_select_stage: RTL

//  Registered, parametrised write-back select stage for the MIPS pipeline.

---
 rtl/wb_select_stage_if.sv | 46 ++++
 rtl/wb_select_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/wb_select_stage_if.sv
// ============================================================================
// Module      : wb_select_stage_if
// Description : Handshake and datapath bundle between MEM, the write-back
//               select stage and the register file.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface wb_select_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        reg_dst;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic [1:0]        wb_sel;
    logic              reg_write;
    logic [2:0]        load_type;
    logic [1:0]        byte_off;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] hilo;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              we;

    modport master (
        output flush, in_valid, reg_dst, rt, rd, wb_sel, reg_write,
               load_type, byte_off, alu_result, mem_data, pc, hilo, out_ready,
        input  in_ready, out_valid, wa, wd, we
    );

    modport slave (
        input  flush, in_valid, reg_dst, rt, rd, wb_sel, reg_write,
               load_type, byte_off, alu_result, mem_data, pc, hilo, out_ready,
        output in_ready, out_valid, wa, wd, we
    );
endinterface

`default_nettype wire

// File: rtl/wb_select_stage.sv
// ============================================================================
// Module      : wb_select_stage
// Description : Registered MIPS write-back select stage (destination, data,
//               load extension) behind a valid/ready 2-entry skid buffer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module wb_select_stage #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int LINK_OFFSET = 8,
    parameter int LINK_REG    = 31
) (
    input  wire logic         clk,
    input  wire logic         reset,
    wb_select_stage_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
    localparam logic [DATA_W-1:0] LINK_INC  = DATA_W'(LINK_OFFSET);

    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    // Entry formed from the live inputs; only meaningful on an accept.
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_wd;
    logic [ADDR_W-1:0] w_wa;
    logic              w_we;

    always_comb begin
        w_byte = bus.mem_data[{bus.byte_off, 3'b000} +: 8];
        w_half = bus.mem_data[{bus.byte_off[1], 4'b0000} +: 16];
        case (bus.load_type)
            LT_LB:   w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LT_LBU:  w_load = {{(DATA_W-8){1'b0}}, w_byte};
            LT_LH:   w_load = {{(DATA_W-16){w_half[15]}}, w_half};
            LT_LHU:  w_load = {{(DATA_W-16){1'b0}}, w_half};
            default: w_load = bus.mem_data;
        endcase

        case (bus.wb_sel)
            2'b00:   w_wd = bus.alu_result;
            2'b01:   w_wd = w_load;
            2'b10:   w_wd = bus.pc + LINK_INC;
            default: w_wd = bus.hilo;
        endcase

        if (bus.reg_dst[1])      w_wa = LINK_ADDR;
        else if (bus.reg_dst[0]) w_wa = bus.rd;
        else                     w_wa = bus.rt;

        w_we = bus.reg_write & (w_wa != '0);
    end

    logic              main_valid_q, main_valid_d;
    logic [ADDR_W-1:0] main_wa_q,    main_wa_d;
    logic [DATA_W-1:0] main_wd_q,    main_wd_d;
    logic              main_we_q,    main_we_d;
    logic              skid_valid_q, skid_valid_d;
    logic [ADDR_W-1:0] skid_wa_q,    skid_wa_d;
    logic [DATA_W-1:0] skid_wd_q,    skid_wd_d;
    logic              skid_we_q,    skid_we_d;
    logic              in_ready_q,   in_ready_d;

    logic w_accept;
    logic w_drain;

    always_comb begin
        w_accept     = bus.in_valid & in_ready_q;
        w_drain      = main_valid_q & bus.out_ready;

        main_valid_d = main_valid_q;
        main_wa_d    = main_wa_q;
        main_wd_d    = main_wd_q;
        main_we_d    = main_we_q;
        skid_valid_d = skid_valid_q;
        skid_wa_d    = skid_wa_q;
        skid_wd_d    = skid_wd_q;
        skid_we_d    = skid_we_q;

        if (bus.flush) begin
            main_valid_d = 1'b0;
            main_wa_d    = '0;
            main_wd_d    = '0;
            main_we_d    = 1'b0;
            skid_valid_d = 1'b0;
            skid_wa_d    = '0;
            skid_wd_d    = '0;
            skid_we_d    = 1'b0;
        end else if (w_drain && skid_valid_q) begin
            // in_ready is low while the skid is full, so no accept can land here.
            main_wa_d    = skid_wa_q;
            main_wd_d    = skid_wd_q;
            main_we_d    = skid_we_q;
            skid_valid_d = 1'b0;
        end else if (w_accept && (!main_valid_q || w_drain)) begin
            main_valid_d = 1'b1;
            main_wa_d    = w_wa;
            main_wd_d    = w_wd;
            main_we_d    = w_we;
        end else if (w_accept) begin
            skid_valid_d = 1'b1;
            skid_wa_d    = w_wa;
            skid_wd_d    = w_wd;
            skid_we_d    = w_we;
        end else if (w_drain) begin
            main_valid_d = 1'b0;
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_wa_q    <= '0;
            main_wd_q    <= '0;
            main_we_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_wa_q    <= '0;
            skid_wd_q    <= '0;
            skid_we_q    <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_wa_q    <= main_wa_d;
            main_wd_q    <= main_wd_d;
            main_we_q    <= main_we_d;
            skid_valid_q <= skid_valid_d;
            skid_wa_q    <= skid_wa_d;
            skid_wd_q    <= skid_wd_d;
            skid_we_q    <= skid_we_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.out_valid = main_valid_q;
    assign bus.wa        = main_wa_q;
    assign bus.wd        = main_wd_q;
    assign bus.we        = main_we_q & main_valid_q;
    assign bus.in_ready  = in_ready_q;

endmodule

`default_nettype wire
